// File: rtl/traffic_sched.sv
// rtl/traffic_sched.sv - two-road traffic light scheduler with pedestrian walk phase
// Optional all-red clearance phases enabled by defining TRAFFIC_ALLRED_EN.
module traffic_sched #(
  parameter int GREEN1_T = 40,
  parameter int GREEN2_T = 20,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_sense2,
  input  logic       ped_req,
  output logic [2:0] light1,
  output logic [2:0] light2,
  output logic [5:0] count,
  output logic       walk
);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    S_G1  = 3'd0,
    S_Y1  = 3'd1,
    S_AR1 = 3'd2,
    S_G2  = 3'd3,
    S_Y2  = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       ped_pend_q, ped_pend_d;
  logic       walk_q, walk_d;
  logic [2:0] light1_q, light1_d;
  logic [2:0] light2_q, light2_d;
  logic       entering_g2;

  function automatic logic [5:0] phase_load(input state_t s);
    case (s)
      S_G1:          phase_load = 6'(GREEN1_T - 1);
      S_G2:          phase_load = 6'(GREEN2_T - 1);
      S_Y1, S_Y2:    phase_load = 6'(YELLOW_T - 1);
      S_AR1, S_AR2:  phase_load = 6'(ALLRED_T - 1);
      default:       phase_load = 6'(GREEN1_T - 1);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q - 6'd1;
    if (count_q == 6'd0) begin
      case (state_q)
        // Main road keeps green until road 2 has a car or a pedestrian waiting.
        S_G1: state_d = (car_sense2 || ped_pend_q) ? S_Y1 : S_G1;
`ifdef TRAFFIC_ALLRED_EN
        S_Y1:  state_d = S_AR1;
        S_AR1: state_d = S_G2;
        S_Y2:  state_d = S_AR2;
        S_AR2: state_d = S_G1;
`else
        S_Y1:  state_d = S_G2;
        S_Y2:  state_d = S_G1;
`endif
        S_G2:    state_d = S_Y2;
        default: state_d = S_G1;
      endcase
      count_d = phase_load(state_d);
    end

    entering_g2 = (state_d == S_G2) && (state_q != S_G2);
    // A press on the entry edge is folded into this G2 rather than left pending.
    if (entering_g2) begin
      walk_d     = ped_pend_q || ped_req;
      ped_pend_d = 1'b0;
    end else begin
      walk_d     = (state_d == S_G2) && walk_q;
      ped_pend_d = ped_pend_q || ped_req;
    end

    light1_d = LAMP_RED;
    light2_d = LAMP_RED;
    case (state_d)
      S_G1:    light1_d = LAMP_GREEN;
      S_Y1:    light1_d = LAMP_YELLOW;
      S_G2:    light2_d = LAMP_GREEN;
      S_Y2:    light2_d = LAMP_YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_G1;
      count_q    <= 6'(GREEN1_T - 1);
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      light1_q   <= LAMP_GREEN;
      light2_q   <= LAMP_RED;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      light1_q   <= light1_d;
      light2_q   <= light2_d;
    end
  end

  assign light1 = light1_q;
  assign light2 = light2_q;
  assign count  = count_q;
  assign walk   = walk_q;

endmodule

// File: tb/tb_traffic_sched.sv
// tb/tb_traffic_sched.sv - randomized and directed checks of traffic_sched against a phase-table model
module tb_traffic_sched;

  logic       clk;
  logic       rst_n;
  logic       car_sense2;
  logic       ped_req;
  logic [2:0] light1;
  logic [2:0] light2;
  logic [5:0] count;
  logic       walk;

  traffic_sched #(
    .GREEN1_T(8),
    .GREEN2_T(5),
    .YELLOW_T(3),
    .ALLRED_T(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .car_sense2(car_sense2),
    .ped_req   (ped_req),
    .light1    (light1),
    .light2    (light2),
    .count     (count),
    .walk      (walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase table: lamp pair and length for each phase in cycle order.
  int         n_ph;
  int         g2_idx;
  int         ph_len [6];
  logic [2:0] ph_l1  [6];
  logic [2:0] ph_l2  [6];

  int   mp, me;
  logic mpend, mwalk;

  int total, passed;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic c, input logic p);
    logic old, entering;
    entering = 1'b0;
    if (!r) begin
      mp = 0; me = 0; mpend = 1'b0; mwalk = 1'b0;
    end else begin
      old = mpend;
      if (me == ph_len[mp] - 1) begin
        me = 0;
        if (mp != 0 || c || old) begin
          mp = (mp + 1) % n_ph;
          entering = (mp == g2_idx);
        end
      end else begin
        me++;
      end
      if (entering) begin
        mwalk = old | p;
        mpend = 1'b0;
      end else begin
        mpend = old | p;
        if (mp != g2_idx) mwalk = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic p);
    @(negedge clk);
    rst_n = r; car_sense2 = c; ped_req = p;
    @(posedge clk);
    model_step(r, c, p);
    #1;
    check("light1", int'(light1), int'(ph_l1[mp]));
    check("light2", int'(light2), int'(ph_l2[mp]));
    check("count", int'(count), ph_len[mp] - 1 - me);
    check("walk", int'(walk), int'(mwalk));
    check("onehot", int'($onehot(light1) && $onehot(light2)), 1);
    check("conflict", int'(light1 != 3'b100 && light2 != 3'b100), 0);
  endtask

  initial begin
    int i, n, rp, re;
    logic seen_ar;
    total = 0; passed = 0;
    rst_n = 1'b0; car_sense2 = 1'b0; ped_req = 1'b0;
`ifdef TRAFFIC_ALLRED_EN
    n_ph = 6; g2_idx = 3;
    ph_len = '{8, 3, 2, 5, 3, 2};
    ph_l1  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    ph_l2  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    n_ph = 4; g2_idx = 2;
    ph_len = '{8, 3, 5, 3, 0, 0};
    ph_l1  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000};
    ph_l2  = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000};
`endif

    // Reset state, then idle main-road extension.
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_count", int'(count), 7);
    check("rst_light1", int'(light1), 1);
    for (i = 0; i < 30; i++) step(1, 0, 0);

    // Continuous demand: measure one full loop back to G1, watching for all-red.
    step(0, 1, 0);
    n = 0; seen_ar = 1'b0;
    do begin
      step(1, 1, 0);
      n++;
      if (light1 == 3'b100 && light2 == 3'b100) seen_ar = 1'b1;
    end while (!(light1 == 3'b001 && n > 8) && n < 100);
`ifdef TRAFFIC_ALLRED_EN
    check("loop_len", n, 23);
    check("allred_seen", int'(seen_ar), 1);
`else
    check("loop_len", n, 19);
    check("allred_seen", int'(seen_ar), 0);
`endif

    // Single pedestrian pulse at cycle 2 with no car.
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    for (i = 0; i < 6; i++) step(1, 0, 0);
    check("ped_y1_at_8", int'(light1), 3'b010);
    for (i = 0; i < 40; i++) step(1, 0, 0);

    // Press exactly on the edge that enters G2.
    step(0, 1, 0);
    n = 0;
    while (!(mp == g2_idx - 1 && me == ph_len[mp] - 1) && n < 100) begin
      step(1, 1, 0); n++;
    end
    check("entry_found", int'(n < 100), 1);
    step(1, 0, 1);
    check("entry_walk", int'(walk), 1);
    for (i = 0; i < 30; i++) step(1, 0, 0);

    // Reset during G2 with count==2.
    step(0, 1, 1);
    n = 0;
    while (!(mp == g2_idx && ph_len[mp] - 1 - me == 2) && n < 100) begin
      step(1, 1, 0); n++;
    end
    check("g2_found", int'(n < 100), 1);
    step(0, 1, 0);
    check("midrst_count", int'(count), 7);
    check("midrst_light2", int'(light2), 3'b100);
    check("midrst_walk", int'(walk), 0);

    // Randomized traffic with occasional resets.
    for (i = 0; i < 800; i++) begin
      rp = $urandom_range(0, 199);
      re = $urandom_range(0, 9);
      step(rp != 0, re < 4, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
